regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file, successor to the current 2-read/1-write file.
- Configurable data width, depth and read-port count.
- Two write ports (ALU result and load/second-issue result).
- Per-register pending-write scoreboard for the decode stage's hazard/stall logic.
- Hardware clear sequencer, so software never sees uninitialised registers.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NREAD, 2, number of combinational read ports (1..4)
DBG_REG, 4, index of register exposed on dbg_o

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
ready_o  out  1  high once clear sequence complete
rd_en_i  in  NREAD  per-port read enable
rd_addr_i  in  NREAD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
rd_data_o  out  NREAD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
rd_busy_o  out  NREAD  scoreboard busy bit of addressed register
we0_i  in  1  write enable, port 0
waddr0_i  in  ADDR_W  write address, port 0
wdata0_i  in  DATA_W  write data, port 0
we1_i  in  1  write enable, port 1 (higher priority)
waddr1_i  in  ADDR_W  write address, port 1
wdata1_i  in  DATA_W  write data, port 1
issue_i  in  1  mark issue_addr_i as pending write
issue_addr_i  in  ADDR_W  destination of issued instruction
any_busy_o  out  1  OR of all busy bits
dbg_o  out  8  register[DBG_REG][7:0], for board LEDs

Behaviour:
- FSM states: CLEAR, RUN.
- rst=1 at a clock edge:
  - state<=CLEAR, clear counter<=0, all busy bits<=0, ready_o<=0.
  - Applies identically mid-operation: in-flight writes that cycle are dropped.
- CLEAR:
  - Each cycle writes 0 to register[counter], counter+1.
  - When counter == 2**ADDR_W-1: that write completes, state<=RUN.
  - ready_o goes high in the cycle after that, i.e. 2**ADDR_W cycles after rst falls (32 for default).
  - we0/we1/issue are ignored.
  - rd_data_o=0 and rd_busy_o=0 on all ports.
- RUN, writes:
  - Write port p takes effect on the next edge if we_p=1 and waddr_p!=0.
  - Both ports to the same address: port 1 data stored, port 0 discarded.
  - Register 0 always reads 0 and is never written.
- RUN, reads (combinational, zero latency), per port k:
  - rd_en=0 or addr=0 -> 0.
  - Else, with forwarding enabled (see Optional Feature): addr matches an active write this cycle -> that write's data, port 1 over port 0.
  - Else -> stored value.
- Scoreboard, per address a != 0, each edge in RUN:
  - set = issue_i && issue_addr_i==a.
  - clr = (we0_i && waddr0_i==a) || (we1_i && waddr1_i==a).
  - set wins over clr (the new producer is pending).
  - clr alone -> 0; neither -> hold.
  - issue to address 0 is ignored; busy[0] is constant 0.
  - rd_busy_o[k] = busy[rd_addr_k] when rd_en_k, else 0. Reflects registered state only; same-cycle clr is not forwarded.
- any_busy_o is registered-state OR; 0 during CLEAR.
- dbg_o:
  - Tracks stored register[DBG_REG][7:0]; no forwarding.
  - 0 after clear.
  - If DATA_W<8, zero-extended.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - Same-cycle write-to-read forwarding as described under Behaviour (RUN, reads).
  - rd_busy_o[k] is forced to 0 when port k's address matches an active write in that cycle.
- Undefined:
  - No forwarding; reads return stored value only.
  - A write becomes visible on the cycle after its edge.
  - rd_busy_o is purely registered.

Test Plan:
- Reset then clear: assert rst 1 cycle, release -> ready_o=0 for 32 cycles, 1 on cycle 33; read any address -> 0x00000000; any_busy_o=0.
- Dual write same address: we0 r5=0x1111_1111, we1 r5=0x2222_2222 same cycle -> next cycle r5 reads 0x22222222; write to r0=0xFFFFFFFF -> r0 reads 0.
- Forwarding: we0 r7=0xDEADBEEF, read port 1 addr 7 same cycle -> 0xDEADBEEF with REGFILE_BYPASS_EN defined; old value (0) without it.
- Scoreboard: issue r9 -> next cycle rd_busy=1, any_busy_o=1; write r9 while issuing r9 same cycle -> busy stays 1; write r9 alone -> busy 0 next cycle.
- Reset mid-operation: r4=0xA5 (dbg_o=0xA5), r3 busy, assert rst -> busy cleared next cycle, writes during CLEAR ignored, after ready_o dbg_o=0x00.
- NREAD=4 build: four simultaneous reads of r1,r2,r3,r0 after writes 1,2,3 -> 1,2,3,0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file.
//   - NREAD combinational read ports, two write ports (port 1 has priority).
//   - Per-register pending-write scoreboard for decode hazard/stall logic.
//   - Hardware clear sequencer zeroes every register after reset.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREAD   = 2,
  parameter int DBG_REG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready_o,
  input  logic [NREAD-1:0]         rd_en_i,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr_i,
  output logic [NREAD*DATA_W-1:0]  rd_data_o,
  output logic [NREAD-1:0]         rd_busy_o,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        waddr0_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        waddr1_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  input  logic                     issue_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  output logic                     any_busy_o,
  output logic [7:0]               dbg_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_REG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    set_vec, clr_vec;
  logic                run;
  logic                act0, act1;

  assign run  = (state_q == RUN);
  // A write is active only in RUN and never targets register 0
  assign act0 = run && we0_i && (waddr0_i != '0);
  assign act1 = run && we1_i && (waddr1_i != '0);

  // Next-state logic: leave CLEAR once the last register has been zeroed
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (&cnt_q) state_d = RUN;
      RUN:   state_d = RUN;
    endcase
  end

  // Control registers: state, clear counter and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == RUN);
      if (!run) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ready_o = ready_q;

  // Register storage: clear sweep in CLEAR, port writes in RUN (port 1 written last so it wins)
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= '0;
    end else if (!rst) begin
      if (act0) mem[waddr0_i] <= wdata0_i;
      if (act1) mem[waddr1_i] <= wdata1_i;
    end
  end

  // Scoreboard set/clear vectors; bit 0 can never be set
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_i) set_vec[issue_addr_i] = 1'b1;
    if (act0)    clr_vec[waddr0_i]     = 1'b1;
    if (act1)    clr_vec[waddr1_i]     = 1'b1;
    set_vec[0] = 1'b0;
  end

  // Scoreboard register: a new issue overrides a completing write to the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (run) begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
    end
  end

  assign any_busy_o = run && (|busy_q);

  // Read ports: zero in CLEAR, when disabled, or for register 0
  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      ra = rd_addr_i[k*ADDR_W +: ADDR_W];
      if (run && rd_en_i[k] && (ra != '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = mem[ra];
        rd_busy_o[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        // Forward a write landing this cycle; its producer is done, so not busy
        if (act1 && (waddr1_i == ra)) begin
          rd_data_o[k*DATA_W +: DATA_W] = wdata1_i;
          rd_busy_o[k]                  = 1'b0;
        end else if (act0 && (waddr0_i == ra)) begin
          rd_data_o[k*DATA_W +: DATA_W] = wdata0_i;
          rd_busy_o[k]                  = 1'b0;
        end
`endif
      end
    end
  end

  // Debug LEDs: low byte of the stored debug register, zero-extended for narrow builds
  if (DATA_W >= 8) begin : g_dbg
    assign dbg_o = mem[DBG_A][7:0];
  end else begin : g_dbg_ext
    assign dbg_o = {{(8-DATA_W){1'b0}}, mem[DBG_A]};
  end

endmodule
